// File: rtl/jump_pkg.sv
// Shared types for the jump prediction unit: BTB entry kinds and counter presets.
package jump_pkg;

    typedef enum logic [2:0] {
        BT_BR,
        BT_J,
        BT_JAL,
        BT_JR_RA,
        BT_JR_OTHER
    } btype_e;

    // 2-bit presets. The top widens them to CTR_W by repeating the low bit,
    // so weak-taken is 10..0 and weak-not-taken is 01..1.
    localparam logic [1:0] CTR_WEAK_NT = 2'b01;
    localparam logic [1:0] CTR_WEAK_T  = 2'b10;

endpackage

// File: rtl/jump_ras.sv
// Return-address stack. When it is full, a push overwrites the oldest entry:
// the pointer wraps and the occupancy count stays at DEPTH.
module jump_ras #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_addr,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] r_stack [DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic [PTR_W-1:0]  w_ptr_inc;
    logic [PTR_W-1:0]  w_ptr_dec;

    assign w_ptr_inc = (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
    assign w_ptr_dec = (r_ptr == '0) ? PTR_LAST : r_ptr - PTR_W'(1);
    assign o_top     = r_stack[w_ptr_dec];
    assign o_empty   = (r_cnt == '0);

    // Stack storage, write pointer and occupancy; a pop on an empty stack is ignored.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_stack[i] <= '0;
            end
        end else if (i_push) begin
            r_stack[r_ptr] <= i_push_addr;
            r_ptr          <= w_ptr_inc;
            if (r_cnt != CNT_FULL) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (i_pop && !o_empty) begin
            r_ptr <= w_ptr_dec;
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/jump_predict_unit.sv
// IF-stage next-PC prediction (direct-mapped BTB plus return-address stack),
// EX-stage jump/branch resolution, and non-speculative training on resolution.
module jump_predict_unit
    import jump_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BTB_DEPTH = 16,
    parameter int RAS_DEPTH = 4,
    parameter int CTR_W     = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_if_pc,
    output logic              o_pred_taken,
    output logic [ADDR_W-1:0] o_pred_target,
    input  logic              i_ex_valid,
    input  logic [ADDR_W-1:0] i_ex_pc_plus_4,
    input  logic [ADDR_W-1:0] i_ex_imm,
    input  logic [25:0]       i_ex_addr_26,
    input  logic [ADDR_W-1:0] i_ex_jr_addr,
    input  logic              i_ex_jr_is_ra,
    input  logic              i_ex_branch,
    input  logic              i_ex_j,
    input  logic              i_ex_jal,
    input  logic              i_ex_jr,
    input  logic              i_ex_cond_taken,
    input  logic              i_ex_pred_taken,
    input  logic [ADDR_W-1:0] i_ex_pred_target,
    output logic [ADDR_W-1:0] o_resolved_pc,
    output logic              o_mispredict,
    output logic [31:0]       o_mispredict_cnt
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_NT  = {CTR_WEAK_NT[1], {(CTR_W-1){CTR_WEAK_NT[0]}}};
    localparam logic [CTR_W-1:0] CTR_T   = {CTR_WEAK_T[1],  {(CTR_W-1){CTR_WEAK_T[0]}}};

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        btype_e            btype;
        logic [ADDR_W-1:0] target;
        logic [CTR_W-1:0]  ctr;
    } btb_entry_t;

    btb_entry_t        r_btb [BTB_DEPTH];
    logic [31:0]       r_mis_cnt;

    btb_entry_t        w_if_entry;
    btb_entry_t        w_ex_entry;
    logic              w_if_hit;
    logic              w_ex_hit;
    logic [ADDR_W-1:0] w_ex_pc;
    logic [IDX_W-1:0]  w_ex_idx;
    logic [TAG_W-1:0]  w_ex_tag;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_jmp_target;
    logic [ADDR_W-1:0] w_store_target;
    logic [ADDR_W-1:0] w_actual_target;
    logic              w_actual_taken;
    logic              w_update;
    btype_e            w_ex_btype;
    logic [CTR_W-1:0]  w_ctr_next;
    logic              w_ras_push;
    logic              w_ras_pop;
    logic [ADDR_W-1:0] w_ras_top;
    logic              w_ras_empty;
    logic              w_unused;

    assign w_unused = ^{i_if_pc[1:0], i_ex_imm[ADDR_W-1:ADDR_W-2], w_ex_pc[1:0]};

    assign w_if_entry = r_btb[i_if_pc[IDX_W+1:2]];
    assign w_if_hit   = w_if_entry.valid && (w_if_entry.tag == i_if_pc[ADDR_W-1:IDX_W+2]);

    assign w_ex_pc      = i_ex_pc_plus_4 - ADDR_W'(4);
    assign w_ex_idx     = w_ex_pc[IDX_W+1:2];
    assign w_ex_tag     = w_ex_pc[ADDR_W-1:IDX_W+2];
    assign w_ex_entry   = r_btb[w_ex_idx];
    assign w_ex_hit     = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);
    assign w_br_target  = i_ex_pc_plus_4 + {i_ex_imm[ADDR_W-3:0], 2'b00};
    assign w_jmp_target = {i_ex_pc_plus_4[ADDR_W-1:28], i_ex_addr_26, 2'b00};

    assign w_actual_taken = i_ex_j | i_ex_jal | i_ex_jr | (i_ex_branch & i_ex_cond_taken);
    assign w_update       = i_ex_valid & (i_ex_branch | i_ex_j | i_ex_jal | i_ex_jr);
    assign w_ras_push     = i_ex_valid & i_ex_jal;
    assign w_ras_pop      = i_ex_valid & i_ex_jr & i_ex_jr_is_ra;

    // IF prediction from the BTB entry as it stands before this edge's write.
    always_comb begin
        o_pred_taken  = 1'b0;
        o_pred_target = i_if_pc + ADDR_W'(4);
        if (w_if_hit) begin
            case (w_if_entry.btype)
                BT_BR: begin
                    if (w_if_entry.ctr[CTR_W-1]) begin
                        o_pred_taken  = 1'b1;
                        o_pred_target = w_if_entry.target;
                    end
                end
                BT_JR_RA: begin
                    if (!w_ras_empty) begin
                        o_pred_taken  = 1'b1;
                        o_pred_target = w_ras_top;
                    end
                end
                default: begin
                    o_pred_taken  = 1'b1;
                    o_pred_target = w_if_entry.target;
                end
            endcase
        end
    end

    // EX resolution: kind of control transfer, real next PC and the target to remember.
    always_comb begin
        w_ex_btype      = BT_BR;
        w_store_target  = w_br_target;
        w_actual_target = i_ex_pc_plus_4;
        if (i_ex_j || i_ex_jal) begin
            w_ex_btype      = i_ex_jal ? BT_JAL : BT_J;
            w_store_target  = w_jmp_target;
            w_actual_target = w_jmp_target;
        end else if (i_ex_jr) begin
            w_ex_btype      = i_ex_jr_is_ra ? BT_JR_RA : BT_JR_OTHER;
            w_store_target  = i_ex_jr_addr;
            w_actual_target = i_ex_jr_addr;
        end else if (i_ex_branch && i_ex_cond_taken) begin
            w_actual_target = w_br_target;
        end
    end

    assign o_resolved_pc = w_actual_target;
    assign o_mispredict  = i_ex_valid &
                           ((w_actual_taken != i_ex_pred_taken) |
                            (w_actual_taken & (w_actual_target != i_ex_pred_target)));

    // Saturating direction counter; a fresh allocation starts weak in the resolved direction.
    always_comb begin
        w_ctr_next = w_actual_taken ? CTR_T : CTR_NT;
        if (w_ex_hit) begin
            if (w_actual_taken) begin
                w_ctr_next = (w_ex_entry.ctr == CTR_MAX) ? CTR_MAX : w_ex_entry.ctr + CTR_W'(1);
            end else begin
                w_ctr_next = (w_ex_entry.ctr == '0) ? '0 : w_ex_entry.ctr - CTR_W'(1);
            end
        end
    end

    // BTB write on every resolved control transfer, including never-taken branches.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                r_btb[i] <= '{valid: 1'b0, tag: '0, btype: BT_BR, target: '0, ctr: CTR_NT};
            end
        end else if (w_update) begin
            r_btb[w_ex_idx] <= '{valid: 1'b1, tag: w_ex_tag, btype: w_ex_btype,
                                 target: w_store_target, ctr: w_ctr_next};
        end
    end

    // Mispredict counter, sticks at all-ones.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mis_cnt <= '0;
        end else if (o_mispredict && (r_mis_cnt != 32'hFFFF_FFFF)) begin
            r_mis_cnt <= r_mis_cnt + 32'd1;
        end
    end

    assign o_mispredict_cnt = r_mis_cnt;

    jump_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_ras_push),
        .i_pop       (w_ras_pop),
        .i_push_addr (i_ex_pc_plus_4),
        .o_top       (w_ras_top),
        .o_empty     (w_ras_empty)
    );

endmodule

// File: tb/tb_jump_predict_unit.sv
// Bench for jump_predict_unit: directed table, hand-written multi-cycle
// sequences and randomized traffic checked against a behavioural model.
module tb_jump_predict_unit;

    localparam int K_NONE = 0, K_BR = 1, K_J = 2, K_JAL = 3, K_JR = 4;
    localparam int T_BR = 0, T_J = 1, T_JAL = 2, T_JRRA = 3, T_JRO = 4;
    localparam int NBTB = 16, NRAS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid, ex_jr_is_ra, ex_branch, ex_j, ex_jal, ex_jr, ex_cond, ex_ptk;
    logic [31:0] ex_pc4, ex_imm, ex_jr_addr, ex_ptg;
    logic [25:0] ex_a26;
    logic [31:0] resolved_pc;
    logic        mispredict;
    logic [31:0] mcnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jump_predict_unit dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_if_pc          (if_pc),
        .o_pred_taken     (pred_taken),
        .o_pred_target    (pred_target),
        .i_ex_valid       (ex_valid),
        .i_ex_pc_plus_4   (ex_pc4),
        .i_ex_imm         (ex_imm),
        .i_ex_addr_26     (ex_a26),
        .i_ex_jr_addr     (ex_jr_addr),
        .i_ex_jr_is_ra    (ex_jr_is_ra),
        .i_ex_branch      (ex_branch),
        .i_ex_j           (ex_j),
        .i_ex_jal         (ex_jal),
        .i_ex_jr          (ex_jr),
        .i_ex_cond_taken  (ex_cond),
        .i_ex_pred_taken  (ex_ptk),
        .i_ex_pred_target (ex_ptg),
        .o_resolved_pc    (resolved_pc),
        .o_mispredict     (mispredict),
        .o_mispredict_cnt (mcnt)
    );

    typedef struct {
        bit          valid;
        int          kind;
        bit          is_ra;
        bit          cond;
        logic [31:0] pc4;
        logic [31:0] imm;
        logic [31:0] jr_addr;
        logic [25:0] a26;
        bit          ptk;
        logic [31:0] ptg;
    } ex_t;

    typedef struct {
        ex_t         e;
        logic [31:0] res;
        bit          mis;
    } vec_t;

    // Behavioural model: per-slot BTB fields, RAS as a queue (newest at the back).
    bit          m_valid [NBTB];
    int unsigned m_tag   [NBTB];
    int          m_type  [NBTB];
    logic [31:0] m_tgt   [NBTB];
    int          m_ctr   [NBTB];
    logic [31:0] m_ras [$];
    int unsigned m_mcnt;

    task automatic model_reset();
        for (int i = 0; i < NBTB; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 0; m_type[i] = T_BR; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_ras.delete();
        m_mcnt = 0;
    endtask

    task automatic model_pred(input logic [31:0] pc, output bit tk, output logic [31:0] tg);
        int idx;
        int unsigned tag;
        idx = int'((pc >> 2) % NBTB);
        tag = pc >> 6;
        tk  = 1'b0;
        tg  = pc + 32'd4;
        if (m_valid[idx] && m_tag[idx] == tag) begin
            if (m_type[idx] == T_BR) begin
                if (m_ctr[idx] >= 2) begin tk = 1'b1; tg = m_tgt[idx]; end
            end else if (m_type[idx] == T_JRRA) begin
                if (m_ras.size() > 0) begin tk = 1'b1; tg = m_ras[$]; end
            end else begin
                tk = 1'b1; tg = m_tgt[idx];
            end
        end
    endtask

    task automatic model_ex(input ex_t e, output logic [31:0] res, output bit mis, output bit taken);
        res   = e.pc4;
        taken = 1'b0;
        case (e.kind)
            K_BR:  if (e.cond) begin taken = 1'b1; res = e.pc4 + e.imm * 4; end
            K_J, K_JAL: begin taken = 1'b1; res = (e.pc4 & 32'hF000_0000) | (32'(e.a26) * 4); end
            K_JR:  begin taken = 1'b1; res = e.jr_addr; end
            default: ;
        endcase
        mis = e.valid && ((taken != e.ptk) || (taken && res != e.ptg));
    endtask

    task automatic model_update(input ex_t e);
        logic [31:0] res, pc;
        bit mis, taken;
        int idx;
        int unsigned tag;
        model_ex(e, res, mis, taken);
        if (!e.valid) return;
        if (mis) m_mcnt++;
        if (e.kind == K_NONE) return;
        pc  = e.pc4 - 32'd4;
        idx = int'((pc >> 2) % NBTB);
        tag = pc >> 6;
        if (m_valid[idx] && m_tag[idx] == tag)
            m_ctr[idx] = taken ? ((m_ctr[idx] < 3) ? m_ctr[idx] + 1 : 3)
                               : ((m_ctr[idx] > 0) ? m_ctr[idx] - 1 : 0);
        else
            m_ctr[idx] = taken ? 2 : 1;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        case (e.kind)
            K_BR:  begin m_type[idx] = T_BR;  m_tgt[idx] = e.pc4 + e.imm * 4; end
            K_J:   begin m_type[idx] = T_J;   m_tgt[idx] = res; end
            K_JAL: begin m_type[idx] = T_JAL; m_tgt[idx] = res; end
            default: begin m_type[idx] = e.is_ra ? T_JRRA : T_JRO; m_tgt[idx] = e.jr_addr; end
        endcase
        if (e.kind == K_JAL) begin
            m_ras.push_back(e.pc4);
            if (m_ras.size() > NRAS) void'(m_ras.pop_front());
        end else if (e.kind == K_JR && e.is_ra && m_ras.size() > 0) begin
            void'(m_ras.pop_back());
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input ex_t e);
        ex_valid    = e.valid;
        ex_branch   = (e.kind == K_BR);
        ex_j        = (e.kind == K_J);
        ex_jal      = (e.kind == K_JAL);
        ex_jr       = (e.kind == K_JR);
        ex_jr_is_ra = e.is_ra;
        ex_cond     = e.cond;
        ex_pc4      = e.pc4;
        ex_imm      = e.imm;
        ex_jr_addr  = e.jr_addr;
        ex_a26      = e.a26;
        ex_ptk      = e.ptk;
        ex_ptg      = e.ptg;
    endtask

    // One EX cycle; has_exp selects hand-computed expectations over the model's.
    task automatic ex_step(input ex_t e, input bit has_exp, input logic [31:0] exp_res,
                           input bit exp_mis, input string name);
        logic [31:0] mres;
        bit mmis, mtk;
        @(negedge clk);
        drive(e);
        #1;
        model_ex(e, mres, mmis, mtk);
        if (!has_exp) begin exp_res = mres; exp_mis = mmis; end
        chk({name, ".resolved"}, resolved_pc, exp_res);
        chk({name, ".mispredict"}, 32'(mispredict), 32'(exp_mis));
        @(posedge clk);
        model_update(e);
    endtask

    task automatic check_pred(input logic [31:0] pc, input bit exp_tk, input logic [31:0] exp_tg,
                              input string name);
        @(negedge clk);
        ex_valid = 1'b0;
        if_pc    = pc;
        #1;
        chk({name, ".taken"}, 32'(pred_taken), 32'(exp_tk));
        chk({name, ".target"}, pred_target, exp_tg);
    endtask

    function automatic ex_t mk(input bit v, input int k, input bit ra, input bit c,
                               input logic [31:0] pc4, input logic [31:0] imm,
                               input logic [31:0] jra, input logic [25:0] a26,
                               input bit ptk, input logic [31:0] ptg);
        ex_t e;
        e.valid = v; e.kind = k; e.is_ra = ra; e.cond = c; e.pc4 = pc4; e.imm = imm;
        e.jr_addr = jra; e.a26 = a26; e.ptk = ptk; e.ptg = ptg;
        return e;
    endfunction

    vec_t tbl [10];

    initial begin
        ex_t e;
        bit tk;
        logic [31:0] tg, pc;

        rst = 1'b1;
        if_pc = 32'h0040_0000;
        drive(mk(0, K_NONE, 0, 0, 32'h4, 0, 0, 0, 0, 32'h4));
        model_reset();

        tbl[0] = '{mk(1, K_NONE, 0, 0, 32'h0000_1000, 0, 0, 0, 0, 32'h0000_1000), 32'h0000_1000, 0};
        tbl[1] = '{mk(1, K_J,    0, 0, 32'h4000_1000, 0, 0, 26'h123, 1, 32'h4000_048C), 32'h4000_048C, 0};
        tbl[2] = '{mk(1, K_JAL,  0, 0, 32'h8000_0010, 0, 0, 26'h3FF_FFFF, 0, 32'h8000_0010), 32'h8FFF_FFFC, 1};
        tbl[3] = '{mk(1, K_BR,   0, 0, 32'h0000_2000, 32'h10, 0, 0, 0, 32'h0000_2000), 32'h0000_2000, 0};
        tbl[4] = '{mk(1, K_BR,   0, 1, 32'hFFFF_FFF0, 32'h8, 0, 0, 1, 32'h0000_0010), 32'h0000_0010, 0};
        tbl[5] = '{mk(1, K_BR,   0, 1, 32'h0000_3000, 32'h4, 0, 0, 1, 32'h0000_3014), 32'h0000_3010, 1};
        tbl[6] = '{mk(1, K_JR,   0, 0, 32'h0000_5000, 0, 32'h1234_5678, 0, 1, 32'h1234_5678), 32'h1234_5678, 0};
        tbl[7] = '{mk(1, K_BR,   0, 0, 32'h0000_2000, 32'h4, 0, 0, 1, 32'h0000_2010), 32'h0000_2000, 1};
        tbl[8] = '{mk(1, K_NONE, 0, 0, 32'h0000_6000, 0, 0, 0, 1, 32'h0000_7000), 32'h0000_6000, 1};
        tbl[9] = '{mk(1, K_BR,   0, 1, 32'h0000_0100, 32'hFFFF_FFFF, 0, 0, 0, 32'h0000_0100), 32'h0000_00FC, 1};

        // Reset state
        #12;
        chk("rst.taken", 32'(pred_taken), 32'h0);
        chk("rst.target", pred_target, 32'h0040_0004);
        chk("rst.cnt", mcnt, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Directed resolution table
        for (int i = 0; i < 10; i++) begin
            ex_step(tbl[i].e, 1'b1, tbl[i].res, tbl[i].mis, $sformatf("tbl%0d", i));
        end
        @(negedge clk);
        ex_valid = 1'b0;
        #1 chk("tbl.cnt", mcnt, 32'd5);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        model_reset();

        // Branch training and counter saturation at the bottom
        ex_step(mk(1, K_BR, 0, 1, 32'h0040_0014, 32'hFFFF_FFFC, 0, 0, 0, 32'h0040_0014), 1, 32'h0040_0004, 1, "br1");
        check_pred(32'h0040_0010, 1, 32'h0040_0004, "br1.lookup");
        ex_step(mk(1, K_BR, 0, 0, 32'h0040_0014, 32'hFFFF_FFFC, 0, 0, 1, 32'h0040_0004), 1, 32'h0040_0014, 1, "br2");
        check_pred(32'h0040_0010, 0, 32'h0040_0014, "br2.lookup");
        ex_step(mk(1, K_BR, 0, 0, 32'h0040_0014, 32'hFFFF_FFFC, 0, 0, 0, 32'h0040_0014), 1, 32'h0040_0014, 0, "br3");
        check_pred(32'h0040_0010, 0, 32'h0040_0014, "br3.lookup");
        ex_step(mk(1, K_BR, 0, 0, 32'h0040_0014, 32'hFFFF_FFFC, 0, 0, 0, 32'h0040_0014), 1, 32'h0040_0014, 0, "br4");
        ex_step(mk(1, K_BR, 0, 1, 32'h0040_0014, 32'hFFFF_FFFC, 0, 0, 0, 32'h0040_0014), 1, 32'h0040_0004, 1, "br5");
        check_pred(32'h0040_0010, 0, 32'h0040_0014, "br.nounderflow");
        chk("br.cnt", mcnt, 32'd3);

        // jal / jr $31 pairing through the RAS
        ex_step(mk(1, K_JAL, 0, 0, 32'h0040_0104, 0, 0, 26'h10_0080, 0, 32'h0040_0104), 1, 32'h0040_0200, 1, "jal1");
        ex_step(mk(1, K_JR, 1, 0, 32'h0040_020C, 0, 32'h0040_0104, 0, 0, 32'h0040_020C), 1, 32'h0040_0104, 1, "jr1");
        check_pred(32'h0040_0208, 0, 32'h0040_020C, "jr.empty");
        check_pred(32'h0040_0100, 1, 32'h0040_0200, "jal.lookup");
        ex_step(mk(1, K_JAL, 0, 0, 32'h0040_0104, 0, 0, 26'h10_0080, 1, 32'h0040_0200), 1, 32'h0040_0200, 0, "jal2");
        check_pred(32'h0040_0208, 1, 32'h0040_0104, "jr.ras");

        // Five nested calls into a four-deep stack, then five returns
        for (int k = 0; k < 5; k++) begin
            ex_step(mk(1, K_JAL, 0, 0, 32'h0040_0334 + 4 * k, 0, 0, 26'h10_0100, 0, 32'h0040_0334 + 4 * k),
                    1, 32'h0040_0400, 1, $sformatf("nest%0d", k));
        end
        for (int k = 0; k < 5; k++) begin
            if (k < 4) check_pred(32'h0040_0208, 1, 32'h0040_0344 - 4 * k, $sformatf("ret%0d", k));
            else       check_pred(32'h0040_0208, 0, 32'h0040_020C, "ret4");
            model_pred(32'h0040_0208, tk, tg);
            ex_step(mk(1, K_JR, 1, 0, 32'h0040_020C, 0, 32'h0040_0344 - 4 * k, 0, tk, tg), 0, 0, 0,
                    $sformatf("retex%0d", k));
        end

        // Bubbles must neither train nor count
        ex_step(mk(0, K_J, 0, 0, 32'h0040_0018, 0, 0, 26'h10_0000, 0, 32'h0040_0018), 1, 32'h0040_0000, 0, "bub.j");
        ex_step(mk(0, K_JAL, 0, 0, 32'h0040_001C, 0, 0, 26'h10_0000, 0, 32'h0040_001C), 1, 32'h0040_0000, 0, "bub.jal");
        check_pred(32'h0040_0014, 0, 32'h0040_0018, "bub.btb");
        check_pred(32'h0040_0208, 0, 32'h0040_020C, "bub.ras");
        chk("bub.cnt", mcnt, m_mcnt);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [31:0] mres;
            bit mmis, mtk;
            pc = 32'h0040_0000 + ($urandom_range(0, 47) << 2);
            if ($urandom_range(0, 9) == 0) pc = $urandom & 32'hFFFF_FFFC;
            e.valid   = ($urandom_range(0, 9) != 0);
            e.kind    = $urandom_range(0, 4);
            e.is_ra   = (e.kind == K_JR) && ($urandom_range(0, 1) == 1);
            e.cond    = $urandom_range(0, 1);
            e.pc4     = pc + 32'd4;
            e.imm     = 32'($signed($urandom_range(0, 63)) - 32);
            e.a26     = 26'(32'h10_0000 + $urandom_range(0, 255));
            e.jr_addr = (e.is_ra && m_ras.size() > 0 && $urandom_range(0, 3) != 0) ? m_ras[$]
                        : 32'h0040_0000 + ($urandom_range(0, 255) << 2);
            model_pred(pc, tk, tg);
            if ($urandom_range(0, 3) == 0) begin tk = ~tk; tg = tg ^ 32'h10; end
            e.ptk = tk;
            e.ptg = tg;
            @(negedge clk);
            drive(e);
            if_pc = 32'h0040_0000 + ($urandom_range(0, 47) << 2);
            #1;
            model_pred(if_pc, tk, tg);
            chk("rnd.taken", 32'(pred_taken), 32'(tk));
            chk("rnd.target", pred_target, tg);
            model_ex(e, mres, mmis, mtk);
            chk("rnd.resolved", resolved_pc, mres);
            chk("rnd.mispredict", 32'(mispredict), 32'(mmis));
            chk("rnd.cnt", mcnt, m_mcnt);
            @(posedge clk);
            model_update(e);
        end

        // Asynchronous reset in the middle of a cycle
        @(negedge clk);
        ex_valid = 1'b0;
        if_pc = 32'h0040_0100;
        #1;
        model_pred(if_pc, tk, tg);
        chk("pre_rst.taken", 32'(pred_taken), 32'(tk));
        chk("pre_rst.cnt", mcnt, m_mcnt);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst.cnt", mcnt, 32'h0);
        chk("mid_rst.taken", 32'(pred_taken), 32'h0);
        chk("mid_rst.target", pred_target, 32'h0040_0104);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_pred(32'h0040_0208, 0, 32'h0040_020C, "post_rst.jr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
